// File: rtl/ram_dp_clr.sv
// ram_dp_clr: simple dual-port RAM (one write port, one read port, one clock)
// with byte-lane write masks, a 1- or 2-cycle read latency, selectable
// same-address collision behaviour, and a clear engine that writes clear_val
// to every word after reset or on request.
//
// Ports:
//   clk    - clock, all logic on posedge
//   rst    - asynchronous active-high reset
//   clear  - single-cycle request to re-initialise the whole array
//   busy   - high while the clear engine owns the write port
//   we     - write enable
//   wmask  - per-lane write enable, lane i = wdata[i*lane_bits +: lane_bits]
//   waddr  - write address
//   wdata  - write data
//   re     - read enable
//   raddr  - read address
//   rdata  - read data, holds its value between reads
//   rvalid - one-cycle strobe marking a completed read
module ram_dp_clr #(
   parameter int unsigned             addr_bits  = 8,
   parameter int unsigned             data_bits  = 16,
   parameter int unsigned             lane_bits  = 8,
   parameter int unsigned             rd_latency = 1,
   parameter int unsigned             bypass     = 1,
   parameter logic [data_bits-1:0]    clear_val  = '0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              clear,
   output logic                              busy,
   input  logic                              we,
   input  logic [(data_bits/lane_bits)-1:0]  wmask,
   input  logic [addr_bits-1:0]              waddr,
   input  logic [data_bits-1:0]              wdata,
   input  logic                              re,
   input  logic [addr_bits-1:0]              raddr,
   output logic [data_bits-1:0]              rdata,
   output logic                              rvalid
);

   localparam int unsigned lanes = data_bits / lane_bits;
   localparam int unsigned depth = 1 << addr_bits;
   localparam logic [addr_bits-1:0] cnt_max = '1;

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t               state;
   logic [addr_bits-1:0] cnt;
   logic [data_bits-1:0] mem [depth];

   logic                 wr_acc_c;
   logic                 rd_acc_c;
   logic [data_bits-1:0] rd_word_c;

   // External requests are only honoured while the clear engine is idle
   assign wr_acc_c = we & ~busy;
   assign rd_acc_c = re & ~busy;

   // Clear engine: sweeps every address once, then returns to IDLE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CLEAR;
         cnt   <= '0;
         busy  <= 1'b1;
      end else begin
         case (state)
            CLEAR: begin
               cnt <= cnt + addr_bits'(1);
               if (cnt == cnt_max) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            IDLE: begin
               if (clear) begin
                  state <= CLEAR;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            default: begin
               state <= CLEAR;
               cnt   <= '0;
               busy  <= 1'b1;
            end
         endcase
      end
   end

   // Storage array: not reset, only initialised by the clear sweep
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[cnt] <= clear_val;
      end else if (wr_acc_c) begin
         for (int i = 0; i < lanes; i++) begin
            if (wmask[i]) begin
               mem[waddr][i*lane_bits +: lane_bits] <= wdata[i*lane_bits +: lane_bits];
            end
         end
      end
   end

   // Read word; with bypass a same-address write is merged lane by lane
   always_comb begin
      rd_word_c = mem[raddr];
      if ((bypass != 0) && wr_acc_c && rd_acc_c && (raddr == waddr)) begin
         for (int i = 0; i < lanes; i++) begin
            if (wmask[i]) begin
               rd_word_c[i*lane_bits +: lane_bits] = wdata[i*lane_bits +: lane_bits];
            end
         end
      end
   end

   generate
      if (rd_latency == 2) begin : g_lat2
         logic [data_bits-1:0] d1;
         logic                 v1;

         // Extra output register stage
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               d1     <= '0;
               v1     <= 1'b0;
               rdata  <= '0;
               rvalid <= 1'b0;
            end else begin
               v1     <= rd_acc_c;
               rvalid <= v1;
               if (rd_acc_c) d1    <= rd_word_c;
               if (v1)       rdata <= d1;
            end
         end
      end else begin : g_lat1
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rdata  <= '0;
               rvalid <= 1'b0;
            end else begin
               rvalid <= rd_acc_c;
               if (rd_acc_c) rdata <= rd_word_c;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_ram_dp_clr.sv
// Bench for ram_dp_clr: two instances share stimulus. Instance a uses the
// default parameters; instance b uses rd_latency=2, bypass=0, clear_val=5A5A.
module tb_ram_dp_clr;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic        we;
   logic [1:0]  wmask;
   logic [7:0]  waddr;
   logic [15:0] wdata;
   logic        re;
   logic [7:0]  raddr;

   logic        busy_a, rvalid_a;
   logic [15:0] rdata_a;
   logic        busy_b, rvalid_b;
   logic [15:0] rdata_b;

   int n_cmp = 0;
   int n_err = 0;
   int n;

   always #5 clk = ~clk;

   ram_dp_clr u_a (
      .clk(clk), .rst(rst), .clear(clear), .busy(busy_a),
      .we(we), .wmask(wmask), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a)
   );

   ram_dp_clr #(.rd_latency(2), .bypass(0), .clear_val(16'h5A5A)) u_b (
      .clk(clk), .rst(rst), .clear(clear), .busy(busy_b),
      .we(we), .wmask(wmask), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [15:0] d, input logic [1:0] m);
      we = 1'b1; waddr = a; wdata = d; wmask = m;
      tick();
      we = 1'b0;
   endtask

   // Single read: a answers one cycle after re, b two cycles after
   task automatic do_read(input string tag, input logic [7:0] a,
                          input logic [15:0] exp_a, input logic [15:0] exp_b);
      re = 1'b1; raddr = a;
      tick();
      re = 1'b0;
      check({tag, "_a_valid"}, 32'(rvalid_a), 32'd1);
      check({tag, "_a_data"},  32'(rdata_a),  32'(exp_a));
      check({tag, "_b_early"}, 32'(rvalid_b), 32'd0);
      tick();
      check({tag, "_a_drop"},  32'(rvalid_a), 32'd0);
      check({tag, "_b_valid"}, 32'(rvalid_b), 32'd1);
      check({tag, "_b_data"},  32'(rdata_b),  32'(exp_b));
   endtask

   // Count cycles until busy falls, bounded
   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (busy_a && cycles < 400) begin
         tick();
         cycles++;
      end
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; we = 1'b0; wmask = 2'b00;
      waddr = '0; wdata = '0; re = 1'b0; raddr = '0;
      tick(); tick();

      // Reset state
      check("rst_busy_a",   32'(busy_a),   32'd1);
      check("rst_busy_b",   32'(busy_b),   32'd1);
      check("rst_rvalid_a", 32'(rvalid_a), 32'd0);
      check("rst_rdata_a",  32'(rdata_a),  32'd0);
      check("rst_rvalid_b", 32'(rvalid_b), 32'd0);
      check("rst_rdata_b",  32'(rdata_b),  32'd0);

      // 1: initial sweep is exactly 256 cycles, then words read clear_val
      rst = 1'b0;
      wait_idle(n);
      check("init_len",    32'(n),      32'd256);
      check("init_busy_b", 32'(busy_b), 32'd0);
      do_read("t1_0",   8'd0,   16'h0000, 16'h5A5A);
      do_read("t1_127", 8'd127, 16'h0000, 16'h5A5A);
      do_read("t1_255", 8'd255, 16'h0000, 16'h5A5A);

      // 2: full-word write then read
      do_write(8'h10, 16'hABCD, 2'b11);
      do_read("t2", 8'h10, 16'hABCD, 16'hABCD);

      // 3: collision, low lane only; a bypasses, b returns old word
      do_write(8'h20, 16'h1234, 2'b11);
      we = 1'b1; waddr = 8'h20; wdata = 16'hAAFF; wmask = 2'b01;
      re = 1'b1; raddr = 8'h20;
      tick();
      we = 1'b0; re = 1'b0;
      check("t3_a_valid", 32'(rvalid_a), 32'd1);
      check("t3_a_merge", 32'(rdata_a),  32'h12FF);
      tick();
      check("t3_b_valid", 32'(rvalid_b), 32'd1);
      check("t3_b_old",   32'(rdata_b),  32'h1234);
      do_read("t3_after", 8'h20, 16'h12FF, 16'h12FF);

      // 4: streaming reads of 0..7
      for (int i = 0; i < 8; i++) do_write(8'(i), 16'(i), 2'b11);
      for (int i = 0; i < 8; i++) begin
         re = 1'b1; raddr = 8'(i);
         tick();
         check($sformatf("t4_a_v%0d", i), 32'(rvalid_a), 32'd1);
         check($sformatf("t4_a_d%0d", i), 32'(rdata_a),  32'(i));
         check($sformatf("t4_b_v%0d", i), 32'(rvalid_b), (i > 0) ? 32'd1 : 32'd0);
         if (i > 0) check($sformatf("t4_b_d%0d", i), 32'(rdata_b), 32'(i - 1));
      end
      re = 1'b0;
      tick();
      check("t4_a_end",  32'(rvalid_a), 32'd0);
      check("t4_b_last", 32'(rvalid_b), 32'd1);
      check("t4_b_d7",   32'(rdata_b),  32'd7);
      tick();
      check("t4_b_end",  32'(rvalid_b), 32'd0);

      // 5: clear request; we/re dropped during sweep, re-request ignored
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("t5_busy", 32'(busy_a), 32'd1);
      n = 0;
      while (busy_a && n < 400) begin
         we = (n < 10); re = (n < 10);
         waddr = 8'd3; wdata = 16'hFFFF; wmask = 2'b11; raddr = 8'd3;
         clear = (n == 100);
         tick();
         n++;
         if (n <= 10) begin
            check($sformatf("t5_a_rv%0d", n), 32'(rvalid_a), 32'd0);
            check($sformatf("t5_b_rv%0d", n), 32'(rvalid_b), 32'd0);
         end
      end
      we = 1'b0; re = 1'b0; clear = 1'b0;
      check("t5_len",    32'(n),      32'd256);
      check("t5_busy_b", 32'(busy_b), 32'd0);
      do_read("t5_3",   8'd3,   16'h0000, 16'h5A5A);
      do_read("t5_0",   8'd0,   16'h0000, 16'h5A5A);
      do_read("t5_200", 8'd200, 16'h0000, 16'h5A5A);

      // 6: read in flight completes across clear; rst mid-sweep restarts it
      do_write(8'd5, 16'hBEEF, 2'b11);
      re = 1'b1; raddr = 8'd5;
      tick();
      re = 1'b0; clear = 1'b1;
      check("t6_a_rv",   32'(rvalid_a), 32'd1);
      check("t6_a_rd",   32'(rdata_a),  32'hBEEF);
      tick();
      clear = 1'b0;
      check("t6_busy",   32'(busy_a),   32'd1);
      check("t6_b_rv",   32'(rvalid_b), 32'd1);
      check("t6_b_rd",   32'(rdata_b),  32'hBEEF);
      for (int i = 0; i < 100; i++) tick();
      rst = 1'b1;
      #1;
      check("t6_rst_busy", 32'(busy_a),   32'd1);
      check("t6_rst_rv_a", 32'(rvalid_a), 32'd0);
      check("t6_rst_rv_b", 32'(rvalid_b), 32'd0);
      tick();
      rst = 1'b0;
      wait_idle(n);
      check("t6_len", 32'(n), 32'd256);
      do_read("t6_100", 8'd100, 16'h0000, 16'h5A5A);
      do_read("t6_255", 8'd255, 16'h0000, 16'h5A5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
